// File: rtl/stg_wb_pkg.sv
// Shared widths and opcodes for the write-back stage and its retire counter.
// Data words are 24 bits and address-class (SR/AR/PC) values are 48 bits.
package stg_wb_pkg;

  localparam int HBIT_ADDR   = 47;
  localparam int HBIT_DATA   = 23;
  localparam int HBIT_OPC    = 5;
  localparam int HBIT_TGT_GP = 3;
  localparam int HBIT_TGT_SR = 1;
  localparam int HBIT_TGT_AR = 1;

  localparam logic [HBIT_OPC:0] OPC_NOP = 6'h00;
  localparam logic [HBIT_OPC:0] OPC_ADD = 6'h01;
  localparam logic [HBIT_OPC:0] OPC_SUB = 6'h02;
  localparam logic [HBIT_OPC:0] OPC_LD  = 6'h10;
  localparam logic [HBIT_OPC:0] OPC_ST  = 6'h11;
  localparam logic [HBIT_OPC:0] OPC_HLT = 6'h3F;

  // A NOP never retires, even when the upstream stage lets it through.
  function automatic logic is_retiring(input logic cap, input logic [HBIT_OPC:0] opc);
    return cap && (opc != OPC_NOP);
  endfunction

endpackage

// File: rtl/wb_retire_ctr.sv
// Free-running retired-instruction counter; wraps modulo 2^CNT_W.
module wb_retire_ctr #(
  parameter int CNT_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stg_wb.sv
// Write-back stage: registers the MO bundle onto the GP/SR/AR write ports,
// counts retirements and stops accepting work after a HLT retires.
module stg_wb
  import stg_wb_pkg::*;
#(
  parameter int CNT_W = 48
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  logic                   iw_stall,
  input  logic [HBIT_ADDR:0]     iw_pc,
  input  logic [HBIT_DATA:0]     iw_instr,
  input  logic [HBIT_OPC:0]      iw_opc,
  input  logic [HBIT_TGT_GP:0]   iw_tgt_gp,
  input  logic                   iw_tgt_gp_we,
  input  logic [HBIT_TGT_SR:0]   iw_tgt_sr,
  input  logic                   iw_tgt_sr_we,
  input  logic [HBIT_TGT_AR:0]   iw_tgt_ar,
  input  logic                   iw_tgt_ar_we,
  input  logic [HBIT_DATA:0]     iw_result,
  input  logic [HBIT_ADDR:0]     iw_sr_result,
  input  logic [HBIT_ADDR:0]     iw_ar_result,
  output logic                   ow_gp_we,
  output logic [HBIT_TGT_GP:0]   ow_gp_tgt,
  output logic [HBIT_DATA:0]     ow_gp_data,
  output logic                   ow_sr_we,
  output logic [HBIT_TGT_SR:0]   ow_sr_tgt,
  output logic [HBIT_ADDR:0]     ow_sr_data,
  output logic                   ow_ar_we,
  output logic [HBIT_TGT_AR:0]   ow_ar_tgt,
  output logic [HBIT_ADDR:0]     ow_ar_data,
  output logic [HBIT_ADDR:0]     ow_pc,
  output logic                   ow_retire,
  output logic [CNT_W-1:0]       ow_retired,
  output logic                   ow_halted
);

  typedef enum logic {
    WB_RUN    = 1'b0,
    WB_HALTED = 1'b1
  } wb_state_e;

  wb_state_e state_q, state_d;
  logic      cap;
  logic      valid;
  logic      unused_instr;

  // The raw instruction word travels with the bundle but nothing here consumes it.
  assign unused_instr = ^iw_instr;

  assign cap   = !iw_stall && (state_q == WB_RUN);
  assign valid = is_retiring(cap, iw_opc);

  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      state_q <= WB_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == WB_RUN && valid && iw_opc == OPC_HLT) begin
      state_d = WB_HALTED;
    end
  end

  assign ow_halted = (state_q == WB_HALTED);

  // Enables are rebuilt every cycle so each one pulses once; tgt/data/pc hold across bubbles.
  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      ow_gp_we   <= 1'b0;
      ow_gp_tgt  <= '0;
      ow_gp_data <= '0;
      ow_sr_we   <= 1'b0;
      ow_sr_tgt  <= '0;
      ow_sr_data <= '0;
      ow_ar_we   <= 1'b0;
      ow_ar_tgt  <= '0;
      ow_ar_data <= '0;
      ow_pc      <= '0;
      ow_retire  <= 1'b0;
    end else begin
      ow_gp_we  <= valid && iw_tgt_gp_we;
      ow_sr_we  <= valid && iw_tgt_sr_we;
      ow_ar_we  <= valid && iw_tgt_ar_we;
      ow_retire <= valid;
      if (valid) begin
        ow_gp_tgt  <= iw_tgt_gp;
        ow_gp_data <= iw_result;
        ow_sr_tgt  <= iw_tgt_sr;
        ow_sr_data <= iw_sr_result;
        ow_ar_tgt  <= iw_tgt_ar;
        ow_ar_data <= iw_ar_result;
        ow_pc      <= iw_pc;
      end
    end
  end

  wb_retire_ctr #(.CNT_W(CNT_W)) u_ctr (
    .clk   (iw_clk),
    .rst_n (iw_rst),
    .inc   (valid),
    .count (ow_retired)
  );

endmodule

// File: tb/tb_stg_wb.sv
// Scoreboard bench for stg_wb: a default-width instance and a 4-bit-counter
// instance share one stimulus stream and are checked against one reference model.
module tb_stg_wb;
  import stg_wb_pkg::*;

  typedef struct {
    logic        stall;
    logic [5:0]  opc;
    logic [47:0] pc;
    logic [23:0] instr;
    logic [3:0]  gp_tgt;
    logic        gp_we;
    logic [1:0]  sr_tgt;
    logic        sr_we;
    logic [1:0]  ar_tgt;
    logic        ar_we;
    logic [23:0] result;
    logic [47:0] sr_result;
    logic [47:0] ar_result;
  } in_t;

  typedef struct {
    logic        gp_we;
    logic [3:0]  gp_tgt;
    logic [23:0] gp_data;
    logic        sr_we;
    logic [1:0]  sr_tgt;
    logic [47:0] sr_data;
    logic        ar_we;
    logic [1:0]  ar_tgt;
    logic [47:0] ar_data;
    logic [47:0] pc;
    logic        retire;
    logic [63:0] cnt;
    logic        halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, gp_we_i, sr_we_i, ar_we_i;
  logic [47:0] pc_i, sr_res_i, ar_res_i;
  logic [23:0] instr_i, res_i;
  logic [5:0]  opc_i;
  logic [3:0]  gp_tgt_i;
  logic [1:0]  sr_tgt_i, ar_tgt_i;

  logic        b_gp_we, b_sr_we, b_ar_we, b_retire, b_halted;
  logic [3:0]  b_gp_tgt;
  logic [1:0]  b_sr_tgt, b_ar_tgt;
  logic [23:0] b_gp_data;
  logic [47:0] b_sr_data, b_ar_data, b_pc, b_retired;
  logic        s_gp_we, s_sr_we, s_ar_we, s_retire, s_halted;
  logic [3:0]  s_gp_tgt, s_retired;
  logic [1:0]  s_sr_tgt, s_ar_tgt;
  logic [23:0] s_gp_data;
  logic [47:0] s_sr_data, s_ar_data, s_pc;

  int n_cmp = 0;
  int n_err = 0;

  exp_t exp_q[$];
  exp_t act_b, act_s, zero_e;

  // Reference model state: what the write-back stage has retired so far.
  logic        m_halted;
  logic [63:0] m_cnt;
  exp_t        m_last;

  always #5 clk = ~clk;

  stg_wb u_big (
    .iw_clk(clk), .iw_rst(rst), .iw_stall(stall), .iw_pc(pc_i), .iw_instr(instr_i),
    .iw_opc(opc_i), .iw_tgt_gp(gp_tgt_i), .iw_tgt_gp_we(gp_we_i), .iw_tgt_sr(sr_tgt_i),
    .iw_tgt_sr_we(sr_we_i), .iw_tgt_ar(ar_tgt_i), .iw_tgt_ar_we(ar_we_i), .iw_result(res_i),
    .iw_sr_result(sr_res_i), .iw_ar_result(ar_res_i),
    .ow_gp_we(b_gp_we), .ow_gp_tgt(b_gp_tgt), .ow_gp_data(b_gp_data),
    .ow_sr_we(b_sr_we), .ow_sr_tgt(b_sr_tgt), .ow_sr_data(b_sr_data),
    .ow_ar_we(b_ar_we), .ow_ar_tgt(b_ar_tgt), .ow_ar_data(b_ar_data),
    .ow_pc(b_pc), .ow_retire(b_retire), .ow_retired(b_retired), .ow_halted(b_halted)
  );

  stg_wb #(.CNT_W(4)) u_small (
    .iw_clk(clk), .iw_rst(rst), .iw_stall(stall), .iw_pc(pc_i), .iw_instr(instr_i),
    .iw_opc(opc_i), .iw_tgt_gp(gp_tgt_i), .iw_tgt_gp_we(gp_we_i), .iw_tgt_sr(sr_tgt_i),
    .iw_tgt_sr_we(sr_we_i), .iw_tgt_ar(ar_tgt_i), .iw_tgt_ar_we(ar_we_i), .iw_result(res_i),
    .iw_sr_result(sr_res_i), .iw_ar_result(ar_res_i),
    .ow_gp_we(s_gp_we), .ow_gp_tgt(s_gp_tgt), .ow_gp_data(s_gp_data),
    .ow_sr_we(s_sr_we), .ow_sr_tgt(s_sr_tgt), .ow_sr_data(s_sr_data),
    .ow_ar_we(s_ar_we), .ow_ar_tgt(s_ar_tgt), .ow_ar_data(s_ar_data),
    .ow_pc(s_pc), .ow_retire(s_retire), .ow_retired(s_retired), .ow_halted(s_halted)
  );

  always_comb begin
    act_b = '{b_gp_we, b_gp_tgt, b_gp_data, b_sr_we, b_sr_tgt, b_sr_data,
              b_ar_we, b_ar_tgt, b_ar_data, b_pc, b_retire, {16'd0, b_retired}, b_halted};
    act_s = '{s_gp_we, s_gp_tgt, s_gp_data, s_sr_we, s_sr_tgt, s_sr_data,
              s_ar_we, s_ar_tgt, s_ar_data, s_pc, s_retire, {60'd0, s_retired}, s_halted};
    zero_e = '{1'b0, 4'd0, 24'd0, 1'b0, 2'd0, 48'd0, 1'b0, 2'd0, 48'd0, 48'd0, 1'b0, 64'd0, 1'b0};
  end

  function automatic void compare(string name, logic [63:0] act, logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endfunction

  function automatic void checkDut(string tag, exp_t a, exp_t e, int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    compare({tag, ".gp_we"},   64'(a.gp_we),   64'(e.gp_we));
    compare({tag, ".gp_tgt"},  64'(a.gp_tgt),  64'(e.gp_tgt));
    compare({tag, ".gp_data"}, 64'(a.gp_data), 64'(e.gp_data));
    compare({tag, ".sr_we"},   64'(a.sr_we),   64'(e.sr_we));
    compare({tag, ".sr_tgt"},  64'(a.sr_tgt),  64'(e.sr_tgt));
    compare({tag, ".sr_data"}, 64'(a.sr_data), 64'(e.sr_data));
    compare({tag, ".ar_we"},   64'(a.ar_we),   64'(e.ar_we));
    compare({tag, ".ar_tgt"},  64'(a.ar_tgt),  64'(e.ar_tgt));
    compare({tag, ".ar_data"}, 64'(a.ar_data), 64'(e.ar_data));
    compare({tag, ".pc"},      64'(a.pc),      64'(e.pc));
    compare({tag, ".retire"},  64'(a.retire),  64'(e.retire));
    compare({tag, ".retired"}, a.cnt,          e.cnt & mask);
    compare({tag, ".halted"},  64'(a.halted),  64'(e.halted));
  endfunction

  function automatic void checkOutput(exp_t e);
    checkDut("big", act_b, e, 48);
    checkDut("small", act_s, e, 4);
  endfunction

  // Monitor: every cycle that had stimulus issued produces one expected bundle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  function automatic void modelReset();
    m_halted = 1'b0;
    m_cnt    = 64'd0;
    m_last   = zero_e;
  endfunction

  // Drive one cycle of inputs and push what the stage should show after the next edge.
  function automatic void driveModel(in_t s);
    logic take;
    stall = s.stall;  opc_i = s.opc;  pc_i = s.pc;  instr_i = s.instr;
    gp_tgt_i = s.gp_tgt;  gp_we_i = s.gp_we;  sr_tgt_i = s.sr_tgt;  sr_we_i = s.sr_we;
    ar_tgt_i = s.ar_tgt;  ar_we_i = s.ar_we;  res_i = s.result;
    sr_res_i = s.sr_result;  ar_res_i = s.ar_result;
    take = !s.stall && !m_halted && (s.opc != OPC_NOP);
    m_last.gp_we  = take && s.gp_we;
    m_last.sr_we  = take && s.sr_we;
    m_last.ar_we  = take && s.ar_we;
    m_last.retire = take;
    if (take) begin
      m_last.gp_tgt  = s.gp_tgt;  m_last.gp_data = s.result;
      m_last.sr_tgt  = s.sr_tgt;  m_last.sr_data = s.sr_result;
      m_last.ar_tgt  = s.ar_tgt;  m_last.ar_data = s.ar_result;
      m_last.pc      = s.pc;
      m_cnt          = m_cnt + 64'd1;
      if (s.opc == OPC_HLT) m_halted = 1'b1;
    end
    m_last.cnt    = m_cnt;
    m_last.halted = m_halted;
    exp_q.push_back(m_last);
  endfunction

  task automatic applyStimulus(input in_t s);
    @(negedge clk);
    driveModel(s);
  endtask

  function automatic in_t randIn();
    in_t s;
    int  r;
    s.stall  = ($urandom_range(0, 3) == 0);
    r = $urandom_range(0, 99);
    if (r < 15)      s.opc = OPC_NOP;
    else if (r < 18) s.opc = OPC_HLT;
    else begin
      case ($urandom_range(0, 3))
        0:       s.opc = OPC_ADD;
        1:       s.opc = OPC_SUB;
        2:       s.opc = OPC_LD;
        default: s.opc = OPC_ST;
      endcase
    end
    s.pc        = {16'($urandom), $urandom};
    s.instr     = 24'($urandom);
    s.gp_tgt    = 4'($urandom);
    s.gp_we     = 1'($urandom);
    s.sr_tgt    = 2'($urandom);
    s.sr_we     = 1'($urandom);
    s.ar_tgt    = 2'($urandom);
    s.ar_we     = 1'($urandom);
    s.result    = 24'($urandom);
    s.sr_result = {16'($urandom), $urandom};
    s.ar_result = {16'($urandom), $urandom};
    return s;
  endfunction

  function automatic in_t mk(logic st, logic [5:0] opc);
    in_t s;
    s = randIn();
    s.stall = st;
    s.opc   = opc;
    return s;
  endfunction

  // Reset lands mid-cycle so the asynchronous clear is observed between edges.
  task automatic doReset();
    in_t s;
    @(posedge clk);
    #3;
    rst = 1'b0;
    s = randIn();
    driveModel(s);
    void'(exp_q.pop_back());
    #1;
    checkDut("rst.big", act_b, zero_e, 48);
    checkDut("rst.small", act_s, zero_e, 4);
    repeat (2) @(negedge clk);
    checkDut("rst_hold.big", act_b, zero_e, 48);
    modelReset();
    rst = 1'b1;
    driveModel(mk(1'b1, OPC_ADD));
  endtask

  initial begin
    in_t s;
    int  waited;
    modelReset();
    driveModel(mk(1'b1, OPC_NOP));
    void'(exp_q.pop_back());
    doReset();

    s = mk(1'b0, OPC_ADD);
    s.gp_tgt = 4'd3;  s.gp_we = 1'b1;  s.sr_we = 1'b0;  s.ar_we = 1'b0;
    s.result = 24'hABCDEF;
    applyStimulus(s);
    applyStimulus(mk(1'b1, OPC_ADD));

    s = mk(1'b0, OPC_LD);
    s.gp_we = 1'b0;  s.sr_we = 1'b1;  s.ar_we = 1'b1;
    s.sr_tgt = 2'd1;  s.sr_result = 48'h123456_ABCDEF;
    s.ar_tgt = 2'd2;  s.ar_result = 48'h000000_00000C;
    applyStimulus(s);
    s.gp_we = 1'b1;  s.sr_result = 48'hFFFF_FFFF_FFFF;  s.ar_result = 48'h8000_0000_0001;
    applyStimulus(s);

    for (int i = 0; i < 5; i++) begin
      s = mk(i < 3, (i < 3) ? OPC_ADD : OPC_NOP);
      s.gp_we = 1'b1;  s.sr_we = 1'b1;  s.ar_we = 1'b1;
      applyStimulus(s);
    end

    doReset();
    applyStimulus(mk(1'b0, OPC_ADD));
    s = mk(1'b1, OPC_HLT);
    applyStimulus(s);
    s = mk(1'b0, OPC_HLT);
    s.gp_we = 1'b1;
    applyStimulus(s);
    s = mk(1'b0, OPC_ADD);
    s.gp_we = 1'b1;
    applyStimulus(s);
    applyStimulus(mk(1'b0, OPC_SUB));
    doReset();
    applyStimulus(mk(1'b0, OPC_NOP));

    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(mk(1'b0, OPC_ADD));
    @(posedge clk);
    #2;
    compare("wrap.small.retired", 64'(s_retired), 64'd0);
    compare("wrap.small.retire", 64'(s_retire), 64'd1);
    compare("wrap.big.retired", 64'(b_retired), 64'd16);

    for (int i = 0; i < 400; i++) begin
      if (m_halted && $urandom_range(0, 7) == 0) doReset();
      else applyStimulus(randIn());
    end
    applyStimulus(mk(1'b1, OPC_NOP));

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    compare("drain.queue_left", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stg_wb.md
Name: stg_wb

Overview:
- Write-back stage; sits directly downstream of the memory-output stage (MO).
- Registers the MO→WB bundle and drives write ports to the GP, SR and AR register files.
- Exposes the registered values as forwarding sources for earlier stages.
- Maintains a retired-instruction counter and a halt state machine.

Parameters:
- CNT_W, 48, width of retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- iw_clk  in  1  clock; all state on rising edge.
- iw_rst  in  1  asynchronous, active-low reset.
- iw_stall  in  1  upstream did not advance this cycle; capture a bubble.
- iw_pc  in  HBIT_ADDR+1  PC of incoming instruction.
- iw_instr  in  HBIT_DATA+1  raw instruction word.
- iw_opc  in  HBIT_OPC+1  decoded opcode.
- iw_tgt_gp  in  HBIT_TGT_GP+1  GP target index.
- iw_tgt_gp_we  in  1  GP write request.
- iw_tgt_sr  in  HBIT_TGT_SR+1  SR target index.
- iw_tgt_sr_we  in  1  SR write request.
- iw_tgt_ar  in  HBIT_TGT_AR+1  AR target index.
- iw_tgt_ar_we  in  1  AR write request.
- iw_result  in  HBIT_DATA+1  24-bit GP result.
- iw_sr_result  in  HBIT_ADDR+1  48-bit SR result.
- iw_ar_result  in  HBIT_ADDR+1  48-bit AR result.
- ow_gp_we / ow_gp_tgt / ow_gp_data  out  1 / HBIT_TGT_GP+1 / HBIT_DATA+1  GP write port (also GP forward source).
- ow_sr_we / ow_sr_tgt / ow_sr_data  out  1 / HBIT_TGT_SR+1 / HBIT_ADDR+1  SR write port.
- ow_ar_we / ow_ar_tgt / ow_ar_data  out  1 / HBIT_TGT_AR+1 / HBIT_ADDR+1  AR write port.
- ow_pc  out  HBIT_ADDR+1  PC of last retired instruction.
- ow_retire  out  1  one-cycle pulse per retired instruction.
- ow_retired  out  CNT_W  retired-instruction count.
- ow_halted  out  1  core halted.

Behaviour:
- Reset (iw_rst=0, async): all outputs 0; FSM state = RUN.
- Latency: one cycle. Values captured at edge N appear on the write ports from N until N+1. Each we is high for exactly one cycle per captured instruction.
- Capture condition: cap = !iw_stall && state==RUN.
- If cap=0, a bubble is latched: all we=0, ow_retire=0, tgt/data/pc hold their previous values.
- Valid instruction: cap && iw_opc != OPC_NOP.
- On a valid capture:
  - ow_*_we copies the matching iw_tgt_*_we.
  - tgt/data are latched.
  - ow_pc = iw_pc.
  - ow_retire = 1.
  - ow_retired increments by 1.
- NOP with cap=1: treated as a bubble; counter does not increment, even if a tgt_we input is set (we forced to 0).
- Simultaneous GP, SR and AR writes are permitted; all three ports fire in the same cycle.
- SR/AR data is passed through at the full 48 bits; no truncation, no sign extension. GP data is 24 bits.
- Counter wrap: at all-ones plus one retire → 0, with ow_retire=1.
- FSM states: RUN, HALTED.
  - RUN→HALTED: valid capture with iw_opc==OPC_HLT.
  - That HLT itself retires: count+1, writes performed if requested, ow_retire=1 for one cycle.
  - ow_halted=1 from the cycle after the HLT capture.
  - HALTED: every later capture is a bubble; counter frozen. Only reset exits HALTED.
- Stall in the same cycle as HLT arrives: HLT is not captured; it is taken on the first non-stalled cycle.
- Reset mid-stream: write enables drop asynchronously. No partial write may be observable after reset deasserts.

Decomposition:
- Shared constants stay in src/sizes.vh: HBIT_ADDR, HBIT_DATA, HBIT_OPC, HBIT_TGT_*.
- Opcodes stay in src/opcodes.vh; OPC_HLT is added there if absent.
- FSM state encodings (WB_RUN=0, WB_HALTED=1) are local parameters of stg_wb.
- One sub-module: wb_retire_ctr (CNT_W counter with increment enable, async active-low reset, wrap).

Test Plan:
- Reset with iw_rst=0 while inputs are random → all outputs 0; after release ow_retired=0, ow_halted=0.
- GP write: opc=ADD, tgt_gp=3, we=1, result=24'hABCDEF → next cycle: ow_gp_we=1, ow_gp_tgt=3, ow_gp_data=ABCDEF, ow_retire=1, ow_retired=1; following cycle ow_gp_we=0.
- 48-bit SR plus AR in the same cycle: sr_result=48'h123456_ABCDEF to SR1, ar_result=48'h000000_00000C to AR2 → both we=1 in one cycle with exact 48-bit data; count+1.
- Stall and NOP: iw_stall=1 with gp_we=1 for 3 cycles, then 2 NOPs with gp_we=1 → ow_gp_we never rises, ow_retired unchanged.
- Halt: ADD, HLT, ADD → ow_retired goes 1→2 then freezes at 2; ow_halted=1 from the cycle after HLT; third ADD produces no write. A reset pulse clears ow_halted.
- Wrap: CNT_W=4; 16 valid instructions → ow_retired reads 0 after the 16th, with ow_retire=1 on that cycle.
